// File: rtl/timer_peripheral_pkg.sv
// Shared definitions for the memory-mapped machine timer: register offsets,
// bus FSM encoding and the byte-lane merge used by every writable register.
package timer_peripheral_pkg;

  localparam logic [3:0] TIMER_MTIME_LO    = 4'h0;
  localparam logic [3:0] TIMER_MTIME_HI    = 4'h4;
  localparam logic [3:0] TIMER_MTIMECMP_LO = 4'h8;
  localparam logic [3:0] TIMER_MTIMECMP_HI = 4'hC;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } bus_state_t;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] w;
    w = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) w[8*i +: 8] = wdata[8*i +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/timer_peripheral_if.sv
// CPU-side bus for the timer slot: decoder select, request, byte strobes,
// and the single-cycle ready/read-data response.
interface timer_peripheral_if;
  logic        enable;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output enable, mem_valid, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  enable, mem_valid, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/timer_prescaler.sv
// Divides clk down to a one-cycle tick every PRESCALE cycles; the first tick
// after reset release lands PRESCALE cycles later.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 100
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] count;

  assign tick = (count == LAST);

  // Count 0..PRESCALE-1 and wrap; with PRESCALE=1 the count stays at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 16'd1;
  end

endmodule

// File: rtl/timer_peripheral.sv
// Memory-mapped 64-bit machine timer with compare interrupt.
//
//   state | meaning
//   IDLE  | waiting for a selected request; a request here commits
//   ACK   | mem_ready high for exactly one cycle, read data driven
module timer_peripheral
  import timer_peripheral_pkg::*;
#(
  parameter int unsigned PRESCALE = 100
) (
  input  logic               clk,
  input  logic               reset,
  timer_peripheral_if.slave  bus,
  output logic               irq
);

  bus_state_t  state, state_next;
  logic        req_fire;
  logic        wr_fire;
  logic        rd_fire;
  logic [3:0]  reg_off;
  logic        tick;
  logic [63:0] mtime, mtime_inc, mtime_next;
  logic [63:0] mtimecmp, mtimecmp_next;
  logic [31:0] shadow;
  logic        shadow_valid;
  logic [31:0] rdata_q, rdata_next;
  logic        addr_unused;

  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Byte-offset bits within a word select nothing.
  assign addr_unused = ^bus.mem_addr[1:0];
  assign reg_off     = {bus.mem_addr[3:2], 2'b00};

  // Bus FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state; the !mem_ready term keeps ACK from ever following ACK.
  always_comb begin
    state_next = state;
    req_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable && bus.mem_valid && !bus.mem_ready) begin
          state_next = ACK;
          req_fire   = 1'b1;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign wr_fire       = req_fire && (|bus.mem_wstrb);
  assign rd_fire       = req_fire && !(|bus.mem_wstrb);
  assign bus.mem_ready = (state == ACK);
  assign bus.mem_rdata = (state == ACK) ? rdata_q : '0;

  // Tick increment first, then written lanes override it, so unwritten lanes
  // of mtime still advance when a write and a tick coincide.
  always_comb begin
    mtime_inc     = tick ? mtime + 64'd1 : mtime;
    mtime_next    = mtime_inc;
    mtimecmp_next = mtimecmp;
    if (wr_fire) begin
      case (reg_off)
        TIMER_MTIME_LO:    mtime_next[31:0]     = merge_bytes(mtime_inc[31:0],     bus.mem_wdata, bus.mem_wstrb);
        TIMER_MTIME_HI:    mtime_next[63:32]    = merge_bytes(mtime_inc[63:32],    bus.mem_wdata, bus.mem_wstrb);
        TIMER_MTIMECMP_LO: mtimecmp_next[31:0]  = merge_bytes(mtimecmp[31:0],  bus.mem_wdata, bus.mem_wstrb);
        TIMER_MTIMECMP_HI: mtimecmp_next[63:32] = merge_bytes(mtimecmp[63:32], bus.mem_wdata, bus.mem_wstrb);
        default: ;
      endcase
    end
  end

  // Read mux; MTIME_HI prefers the half captured by the last MTIME_LO read.
  always_comb begin
    rdata_next = '0;
    case (reg_off)
      TIMER_MTIME_LO:    rdata_next = mtime[31:0];
      TIMER_MTIME_HI:    rdata_next = shadow_valid ? shadow : mtime[63:32];
      TIMER_MTIMECMP_LO: rdata_next = mtimecmp[31:0];
      TIMER_MTIMECMP_HI: rdata_next = mtimecmp[63:32];
      default:           rdata_next = '0;
    endcase
  end

  // Counter, compare register and registered interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime    <= '0;
      mtimecmp <= '1;
      irq      <= 1'b0;
    end else begin
      mtime    <= mtime_next;
      mtimecmp <= mtimecmp_next;
      irq      <= (mtime >= mtimecmp);
    end
  end

  // Read data capture and tear-free high-word shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q      <= '0;
      shadow       <= '0;
      shadow_valid <= 1'b0;
    end else begin
      if (rd_fire) rdata_q <= rdata_next;
      if (rd_fire && reg_off == TIMER_MTIME_LO) begin
        shadow       <= mtime[63:32];
        shadow_valid <= 1'b1;
      end
      if (wr_fire && (reg_off == TIMER_MTIME_LO || reg_off == TIMER_MTIME_HI))
        shadow_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_peripheral.sv
// Directed bench for the timer peripheral: two instances (PRESCALE=4 and 1),
// stimulus pushes expected read data, per-instance monitors pop on mem_ready.
module tb_timer_peripheral;
  import timer_peripheral_pkg::*;

  typedef struct packed {
    logic        chk;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst4 = 1'b1;
  logic irq1, irq4;
  int   checks = 0;
  int   failures = 0;
  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  timer_peripheral_if ifc1();
  timer_peripheral_if ifc4();

  timer_peripheral #(.PRESCALE(1)) dut1 (.clk(clk), .reset(rst1), .bus(ifc1), .irq(irq1));
  timer_peripheral #(.PRESCALE(4)) dut4 (.clk(clk), .reset(rst4), .bus(ifc4), .irq(irq4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every mem_ready cycle consumes one scoreboard entry.
  always @(negedge clk) begin
    if (ifc1.mem_ready === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ready1: got ready=1 expected no transfer at %0t", $time);
      end else begin
        exp_t e;
        e = q1.pop_front();
        if (e.chk) check("rdata1", ifc1.mem_rdata, e.exp);
      end
    end
  end

  always @(negedge clk) begin
    if (ifc4.mem_ready === 1'b1) begin
      if (q4.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ready4: got ready=1 expected no transfer at %0t", $time);
      end else begin
        exp_t e;
        e = q4.pop_front();
        if (e.chk) check("rdata4", ifc4.mem_rdata, e.exp);
      end
    end
  end

  // One transfer on dut1; called and returns at posedge+1.
  task automatic xfer1(input logic [3:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] wdata, input logic chk, input logic [31:0] exp);
    q1.push_back('{chk: chk, exp: exp});
    ifc1.enable = 1'b1; ifc1.mem_valid = 1'b1; ifc1.mem_addr = addr;
    ifc1.mem_wstrb = wstrb; ifc1.mem_wdata = wdata;
    @(posedge clk); #1;
    ifc1.enable = 1'b0; ifc1.mem_valid = 1'b0; ifc1.mem_wstrb = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic rd1(input logic [3:0] addr, input logic [31:0] exp);
    xfer1(addr, 4'h0, 32'h0, 1'b1, exp);
  endtask

  task automatic wr1(input logic [3:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
    xfer1(addr, wstrb, wdata, 1'b0, 32'h0);
  endtask

  // Leaves dut1 freshly released at posedge+1 with mtime=0.
  task automatic reset1();
    rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b0;
  endtask

  initial begin
    ifc1.enable = 1'b0; ifc1.mem_valid = 1'b0; ifc1.mem_addr = 4'h0;
    ifc1.mem_wstrb = 4'h0; ifc1.mem_wdata = 32'h0;
    ifc4.enable = 1'b0; ifc4.mem_valid = 1'b0; ifc4.mem_addr = 4'h0;
    ifc4.mem_wstrb = 4'h0; ifc4.mem_wdata = 32'h0;

    @(posedge clk); #1;
    check("rst_ready4", 32'(ifc4.mem_ready), 32'h0);
    check("rst_rdata4", ifc4.mem_rdata, 32'h0);
    check("rst_irq4",   32'(irq4), 32'h0);
    check("rst_ready1", 32'(ifc1.mem_ready), 32'h0);
    check("rst_rdata1", ifc1.mem_rdata, 32'h0);
    check("rst_irq1",   32'(irq1), 32'h0);

    // Scenario 1: PRESCALE=4, 40 idle cycles -> mtime=10.
    rst4 = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    q4.push_back('{chk: 1'b1, exp: 32'd10});
    ifc4.enable = 1'b1; ifc4.mem_valid = 1'b1; ifc4.mem_addr = TIMER_MTIME_LO;
    @(posedge clk); #1;
    ifc4.enable = 1'b0; ifc4.mem_valid = 1'b0;
    @(negedge clk);
    check("s1_irq", 32'(irq4), 32'h0);
    @(posedge clk); #1;

    // Scenario 2: valid held across three edges; acks on edges 4 and 6 only.
    reset1();
    repeat (3) @(posedge clk);
    #1;
    q1.push_back('{chk: 1'b1, exp: 32'd3});
    q1.push_back('{chk: 1'b1, exp: 32'd5});
    ifc1.enable = 1'b1; ifc1.mem_valid = 1'b1; ifc1.mem_addr = TIMER_MTIME_LO; ifc1.mem_wstrb = 4'h0;
    @(negedge clk);
    check("s2_ready_before", 32'(ifc1.mem_ready), 32'h0);
    @(posedge clk); @(negedge clk);
    check("s2_ready_ack", 32'(ifc1.mem_ready), 32'h1);
    @(posedge clk); @(negedge clk);
    check("s2_ready_gap", 32'(ifc1.mem_ready), 32'h0);
    @(posedge clk); #1;
    ifc1.enable = 1'b0; ifc1.mem_valid = 1'b0;
    @(posedge clk); #1;

    // Scenario 3: tear-free read across the 32-bit carry.
    wr1(TIMER_MTIME_HI, 4'hF, 32'h0);
    wr1(TIMER_MTIME_LO, 4'hF, 32'hFFFF_FFFE);
    rd1(TIMER_MTIME_LO, 32'hFFFF_FFFF);
    rd1(TIMER_MTIME_HI, 32'h0);
    wr1(TIMER_MTIME_LO, 4'hF, 32'h0);
    rd1(TIMER_MTIME_HI, 32'h1);

    // Scenario 4: compare at 20, then raise compare above mtime.
    reset1();
    wr1(TIMER_MTIME_HI,    4'hF, 32'h0);
    wr1(TIMER_MTIME_LO,    4'hF, 32'h0);
    wr1(TIMER_MTIMECMP_LO, 4'hF, 32'd20);
    wr1(TIMER_MTIMECMP_HI, 4'hF, 32'h0);
    rd1(TIMER_MTIME_LO, 32'd5);
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("s4_irq_at_20", 32'(irq1), 32'h0);
    @(posedge clk); @(negedge clk);
    check("s4_irq_rise", 32'(irq1), 32'h1);
    @(posedge clk); #1;
    wr1(TIMER_MTIMECMP_HI, 4'hF, 32'h1);
    @(negedge clk);
    check("s4_irq_fall", 32'(irq1), 32'h0);
    @(posedge clk); #1;

    // Scenario 5: byte-lane writes, including mtime write coinciding with a tick.
    reset1();
    wr1(TIMER_MTIMECMP_LO, 4'b0010, 32'h0000_AB00);
    rd1(TIMER_MTIMECMP_LO, 32'hFFFF_ABFF);
    rd1(TIMER_MTIMECMP_HI, 32'hFFFF_FFFF);
    wr1(TIMER_MTIME_HI, 4'hF, 32'h1234_5678);
    wr1(TIMER_MTIME_LO, 4'b0001, 32'h0000_00AA);
    rd1(TIMER_MTIME_LO, 32'h0000_00AB);
    rd1(TIMER_MTIME_HI, 32'h1234_5678);

    // Scenario 6: reset during ACK, then deselected requests.
    ifc1.enable = 1'b1; ifc1.mem_valid = 1'b1; ifc1.mem_addr = TIMER_MTIMECMP_LO;
    ifc1.mem_wstrb = 4'hF; ifc1.mem_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    ifc1.enable = 1'b0; ifc1.mem_valid = 1'b0; ifc1.mem_wstrb = 4'h0;
    check("s6_ack_before_rst", 32'(ifc1.mem_ready), 32'h1);
    rst1 = 1'b1;
    #1;
    check("s6_ready_in_rst", 32'(ifc1.mem_ready), 32'h0);
    check("s6_rdata_in_rst", ifc1.mem_rdata, 32'h0);
    check("s6_irq_in_rst",   32'(irq1), 32'h0);
    reset1();
    rd1(TIMER_MTIMECMP_LO, 32'hFFFF_FFFF);
    rd1(TIMER_MTIMECMP_HI, 32'hFFFF_FFFF);
    rd1(TIMER_MTIME_HI, 32'h0);
    ifc1.enable = 1'b0; ifc1.mem_valid = 1'b1; ifc1.mem_addr = TIMER_MTIMECMP_LO;
    ifc1.mem_wstrb = 4'hF; ifc1.mem_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      check("s6_desel_ready", 32'(ifc1.mem_ready), 32'h0);
      check("s6_desel_rdata", ifc1.mem_rdata, 32'h0);
    end
    @(posedge clk); #1;
    ifc1.mem_valid = 1'b0; ifc1.mem_wstrb = 4'h0;
    rd1(TIMER_MTIMECMP_LO, 32'hFFFF_FFFF);

    repeat (2) @(posedge clk);
    check("q1_drained", 32'(q1.size()), 32'h0);
    check("q4_drained", 32'(q4.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/timer_peripheral.md
TIMER_PERIPHERAL -- requirements
Module: timer_peripheral

Interface
REQ-001 Parameter PRESCALE, default 100, clk cycles per mtime increment (legal range 1..65535).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  address-decoder select for the timer slot (0xffff0030..0xffff003f).
REQ-005 mem_valid  input  1  CPU bus request valid.
REQ-006 mem_addr  input  4  byte offset within slot; bits [3:2] select the register, bits [1:0] are ignored.
REQ-007 mem_wstrb  input  4  byte write strobes; all-zero means read.
REQ-008 mem_wdata  input  32  write data.
REQ-009 mem_rdata  output  32  read data, valid while mem_ready=1, else 0.
REQ-010 mem_ready  output  1  single-cycle transfer acknowledge, returned to the decoder's timer ready input.
REQ-011 irq  output  1  timer interrupt, level, registered.

Function
REQ-012 Register map: 0x0 MTIME_LO, 0x4 MTIME_HI, 0x8 MTIMECMP_LO, 0xC MTIMECMP_HI; all are read/write.
REQ-013 Prescaler counts 0..PRESCALE-1 and emits a one-cycle tick on wrap. With PRESCALE=1, tick is asserted every cycle.
REQ-014 mtime (64 bit) increments by 1 on each tick, wrapping from 2^64-1 to 0.
REQ-015 Bus FSM states: IDLE, ACK.
  - IDLE->ACK when enable & mem_valid & !mem_ready.
  - ACK->IDLE unconditionally.
  - mem_ready=1 only in ACK, so latency is exactly one cycle from request to ready.
REQ-016 mem_ready never asserts on two consecutive cycles; a request held across the ACK cycle is not re-acknowledged until IDLE has been observed for one cycle.
REQ-017 Writes commit at the IDLE->ACK edge, per byte lane, only for lanes with mem_wstrb[i]=1.
REQ-018 Read data is sampled at the IDLE->ACK edge into a register and driven during ACK.
REQ-019 Tear-free read: reading MTIME_LO captures mtime[63:32] into a shadow register at the same edge. A subsequent MTIME_HI read returns the shadow, not live mtime.
REQ-020 Writing MTIME_LO or MTIME_HI clears the shadow-valid flag. While shadow-valid is 0, MTIME_HI reads return live mtime[63:32].
REQ-021 A bus write to mtime and a tick in the same cycle: the written bytes take the written value, unwritten bytes take the incremented value, and the prescaler is not reset.
REQ-022 irq is registered as (mtime >= mtimecmp), unsigned 64-bit compare, so it lags a state change by one cycle.
REQ-023 Writing MTIMECMP to a value above mtime deasserts irq on the cycle after the commit edge.
REQ-024 When enable=0, no state changes from the bus, mem_ready stays 0 and mem_rdata stays 0.

Reset
REQ-025 Asserting reset forces, asynchronously:
  - FSM to IDLE, mem_ready=0, mem_rdata=0
  - prescaler=0, mtime=0
  - mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, irq=0
  - shadow=0, shadow-valid=0
REQ-026 Reset asserted during ACK aborts the transfer: no partial write persists beyond the edge that already committed it, and mem_ready drops immediately.
REQ-027 After reset deasserts, the first tick occurs PRESCALE cycles later.

Structure
REQ-028 Shared package contents:
  - register offset constants: TIMER_MTIME_LO, TIMER_MTIME_HI, TIMER_MTIMECMP_LO, TIMER_MTIMECMP_HI
  - bus FSM state encoding (IDLE, ACK)
REQ-029 The prescaler is a sub-module timer_prescaler (params PRESCALE; ports clk, reset, tick); all other logic is inline.

Verification
REQ-030 Scenario 1 (reset/increment): PRESCALE=4, release reset, idle 40 cycles -> MTIME_LO reads 10, irq=0.
REQ-031 Scenario 2 (handshake latency): read MTIME_LO with mem_valid held 3 cycles -> mem_ready high exactly 1 cycle, on the cycle after the first valid, then low for at least 1 cycle.
REQ-032 Scenario 3 (tear-free read): write mtime=0x0000_0000_FFFF_FFFE, PRESCALE=1. Read LO, then HI -> LO in {0xFFFF_FFFF, 0x0000_0000}, and HI returns the value consistent with that LO (0 or 1).
REQ-033 Scenario 4 (compare): write MTIMECMP=20, mtime=0, PRESCALE=1 -> irq rises 1 cycle after mtime reaches 20. Then write MTIMECMP_HI=1 -> irq=0 on the cycle after the commit.
REQ-034 Scenario 5 (byte write): write mem_wstrb=4'b0010, mem_wdata=0x0000_AB00 to MTIMECMP_LO after reset -> MTIMECMP_LO reads 0xFFFF_ABFF.
REQ-035 Scenario 6 (mid-transfer reset and deselect): assert reset during ACK -> mem_ready=0 the same cycle, all registers at reset values. With enable=0 and mem_valid=1 -> no write, mem_ready stays 0.
